// File: rtl/vlsu_shf_cmt_sched_if.sv
// Request/descriptor/completion bus of the deshuffle commit scheduler, plus the shared descriptor type.
// All three channels use valid/ready: a beat transfers on a cycle where valid and ready are both high,
// and a source holds valid and payload stable until that cycle; cmt_fire_i is a bare pulse with no ready.
package vlsu_shf_cmt_pkg;
  localparam int unsigned ReqIdBits = 4;
  localparam int unsigned VlBits    = 16;

  typedef struct packed {
    logic [ReqIdBits-1:0] req_id;
    logic [1:0]           mode;
    logic [1:0]           sew;
    logic [4:0]           vd;
    logic [VlBits-1:0]    vstart;
    logic [VlBits-1:0]    vl;
    logic                 vm;
    logic [VlBits-1:0]    cmt_cnt;
  } meta_glb_t;
endpackage

interface vlsu_shf_cmt_sched_if;
  logic                                      req_valid_i;
  logic                                      req_ready_o;
  vlsu_shf_cmt_pkg::meta_glb_t               req_i;
  logic                                      meta_valid_o;
  logic                                      meta_ready_i;
  vlsu_shf_cmt_pkg::meta_glb_t               meta_o;
  logic                                      cmt_fire_i;
  logic                                      done_valid_o;
  logic                                      done_ready_i;
  logic [vlsu_shf_cmt_pkg::ReqIdBits-1:0]    done_reqid_o;

  modport master (
    output req_valid_i, req_i, meta_ready_i, cmt_fire_i, done_ready_i,
    input  req_ready_o, meta_valid_o, meta_o, done_valid_o, done_reqid_o
  );

  modport slave (
    input  req_valid_i, req_i, meta_ready_i, cmt_fire_i, done_ready_i,
    output req_ready_o, meta_valid_o, meta_o, done_valid_o, done_reqid_o
  );
endinterface

// File: rtl/vlsu_shf_cmt_sched.sv
// Load-side commit scheduler: registers each request with its commit count, issues descriptors under
// a credit limit, attributes commit pulses to the oldest tracked request and retires in order.
module vlsu_shf_cmt_sched
  import vlsu_shf_cmt_pkg::*;
#(
  parameter int unsigned NrLanes     = 4,
  parameter int unsigned DLEN        = 64,
  parameter int unsigned MaxInflight = 4
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  vlsu_shf_cmt_sched_if.slave  bus,
  output logic                 busy_o,
  output logic                 err_o
);
  localparam int unsigned LogEpc0 = $clog2(NrLanes * DLEN / 8);
  localparam int unsigned PtrW    = $clog2(MaxInflight);
  localparam int unsigned CredW   = PtrW + 1;
  typedef logic [PtrW:0] ptr_t;

  logic                 s0_valid_q, s0_valid_d, s0_zero_q, s0_zero_d;
  meta_glb_t            s0_meta_q, s0_meta_d;
  logic [CredW-1:0]     cred_q, cred_d;
  logic [ReqIdBits-1:0] trk_id_q   [MaxInflight];
  logic [ReqIdBits-1:0] trk_id_d   [MaxInflight];
  logic [VlBits-1:0]    trk_rem_q  [MaxInflight];
  logic [VlBits-1:0]    trk_rem_d  [MaxInflight];
  logic                 trk_zero_q [MaxInflight];
  logic                 trk_zero_d [MaxInflight];
  ptr_t                 trk_wr_q, trk_wr_d, trk_rd_q, trk_rd_d;
  logic [ReqIdBits-1:0] dn_id_q    [MaxInflight];
  logic [ReqIdBits-1:0] dn_id_d    [MaxInflight];
  ptr_t                 dn_wr_q, dn_wr_d, dn_rd_q, dn_rd_d;
  logic                 err_q, err_d;

  logic [4:0]           shamt;
  logic [VlBits-1:0]    first_idx, last_idx;
  logic                 req_zero, req_fire, cred_ok, s0_leave;
  meta_glb_t            req_calc;
  logic [PtrW-1:0]      trk_head, trk_tail, dn_head, dn_tail;
  logic                 trk_empty, dn_empty, h_zero, trk_retire, trk_dec, done_pop;
  logic [VlBits-1:0]    h_rem;

  // Elements per commit is a power of two, so the commit index is a plain right shift.
  always_comb begin
    shamt     = 5'(LogEpc0) - 5'(bus.req_i.sew);
    first_idx = bus.req_i.vstart >> shamt;
    last_idx  = (bus.req_i.vl - VlBits'(1)) >> shamt;
    req_zero  = bus.req_i.vl <= bus.req_i.vstart;
    req_calc  = bus.req_i;
    req_calc.cmt_cnt = req_zero ? '0 : last_idx - first_idx;
  end

  assign cred_ok          = cred_q != '0;
  assign s0_leave         = s0_valid_q & cred_ok & (s0_zero_q | bus.meta_ready_i);
  assign bus.meta_valid_o = s0_valid_q & ~s0_zero_q & cred_ok;
  assign bus.meta_o       = s0_meta_q;
  assign bus.req_ready_o  = ~s0_valid_q | s0_leave;
  assign req_fire         = bus.req_valid_i & bus.req_ready_o;

  assign trk_head   = trk_rd_q[PtrW-1:0];
  assign trk_tail   = trk_wr_q[PtrW-1:0];
  assign trk_empty  = trk_wr_q == trk_rd_q;
  assign h_zero     = trk_zero_q[trk_head];
  assign h_rem      = trk_rem_q[trk_head];
  // A pulse only counts against a non-zero head; zero heads retire on their own.
  assign trk_retire = ~trk_empty & (h_zero | (bus.cmt_fire_i & (h_rem == '0)));
  assign trk_dec    = ~trk_empty & ~h_zero & bus.cmt_fire_i & (h_rem != '0);

  assign dn_head          = dn_rd_q[PtrW-1:0];
  assign dn_tail          = dn_wr_q[PtrW-1:0];
  assign dn_empty         = dn_wr_q == dn_rd_q;
  assign bus.done_valid_o = ~dn_empty;
  assign bus.done_reqid_o = dn_id_q[dn_head];
  assign done_pop         = ~dn_empty & bus.done_ready_i;

  assign busy_o = s0_valid_q | ~trk_empty | ~dn_empty;
  assign err_o  = err_q;

  always_comb begin
    s0_valid_d = s0_valid_q;
    s0_zero_d  = s0_zero_q;
    s0_meta_d  = s0_meta_q;
    if (s0_leave) s0_valid_d = 1'b0;
    if (req_fire) begin
      s0_valid_d = 1'b1;
      s0_zero_d  = req_zero;
      s0_meta_d  = req_calc;
    end
    cred_d = cred_q - CredW'(s0_leave) + CredW'(done_pop);
    err_d  = err_q | (bus.cmt_fire_i & (trk_empty | h_zero));
  end

  always_comb begin
    trk_id_d   = trk_id_q;
    trk_rem_d  = trk_rem_q;
    trk_zero_d = trk_zero_q;
    trk_wr_d   = trk_wr_q;
    trk_rd_d   = trk_rd_q;
    if (trk_dec)    trk_rem_d[trk_head] = h_rem - VlBits'(1);
    if (trk_retire) trk_rd_d = trk_rd_q + ptr_t'(1);
    if (s0_leave) begin
      trk_id_d[trk_tail]   = s0_meta_q.req_id;
      trk_rem_d[trk_tail]  = s0_meta_q.cmt_cnt;
      trk_zero_d[trk_tail] = s0_zero_q;
      trk_wr_d             = trk_wr_q + ptr_t'(1);
    end
  end

  always_comb begin
    dn_id_d = dn_id_q;
    dn_wr_d = dn_wr_q;
    dn_rd_d = dn_rd_q;
    if (done_pop) dn_rd_d = dn_rd_q + ptr_t'(1);
    if (trk_retire) begin
      dn_id_d[dn_tail] = trk_id_q[trk_head];
      dn_wr_d          = dn_wr_q + ptr_t'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      s0_valid_q <= 1'b0;
      s0_zero_q  <= 1'b0;
      s0_meta_q  <= '0;
      cred_q     <= CredW'(MaxInflight);
      err_q      <= 1'b0;
      trk_wr_q   <= '0;
      trk_rd_q   <= '0;
      dn_wr_q    <= '0;
      dn_rd_q    <= '0;
      for (int i = 0; i < MaxInflight; i++) begin
        trk_id_q[i]   <= '0;
        trk_rem_q[i]  <= '0;
        trk_zero_q[i] <= 1'b0;
        dn_id_q[i]    <= '0;
      end
    end else begin
      s0_valid_q <= s0_valid_d;
      s0_zero_q  <= s0_zero_d;
      s0_meta_q  <= s0_meta_d;
      cred_q     <= cred_d;
      err_q      <= err_d;
      trk_wr_q   <= trk_wr_d;
      trk_rd_q   <= trk_rd_d;
      dn_wr_q    <= dn_wr_d;
      dn_rd_q    <= dn_rd_d;
      trk_id_q   <= trk_id_d;
      trk_rem_q  <= trk_rem_d;
      trk_zero_q <= trk_zero_d;
      dn_id_q    <= dn_id_d;
    end
  end
endmodule
